// File: rtl/shift_sched_pkg.sv
// Shared FSM encodings, width helper and frame counter width for the shift frame scheduler.
package shift_sched_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_frame_scheduler_if.sv
// Requester/scheduler bundle: request side, serial chain drive and frame status.
interface shift_frame_scheduler_if import shift_sched_pkg::*; #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 8
) ();

    localparam int IDW = clog2(N_REQ);

    // Handshake: req[i] is a level held with data[i] stable until the one-cycle gnt[i]
    // pulse, which marks the word as captured; req may then drop or stay high to re-queue.
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic                   sr_data;
    logic                   frame_valid;
    logic [IDW-1:0]         frame_id;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    sched_state_e           dbg_state;

    modport master (
        output req, data,
        input  gnt, sr_data, frame_valid, frame_id, busy, frame_cnt, dbg_state
    );

    modport slave (
        input  req, data,
        output gnt, sr_data, frame_valid, frame_id, busy, frame_cnt, dbg_state
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter import shift_sched_pkg::*; #(
    parameter  int N_REQ = 3,
    localparam int IDW   = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/shift_frame_scheduler.sv
// Round-robin scheduler serialising one requester word MSB-first onto a free-running shift chain.
// Optional frame counter built when SHIFT_SCHED_FRAME_CNT_EN is defined; otherwise frame_cnt is 0.
module shift_frame_scheduler import shift_sched_pkg::*; #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input logic                    clk,
    input logic                    reset,
    shift_frame_scheduler_if.slave sif
);

    localparam int IDW = clog2(N_REQ);
    localparam int CW  = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam int GW  = 4;

    sched_state_e     state, state_nx;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] word;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    logic [N_REQ-1:0] gnt_d, gnt_q;
    logic             sr_d, sr_q;
    logic             fv_d, fv_q;
    logic [IDW-1:0]   frame_id_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (sif.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nx = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == '0) state_nx = ST_LATCH;
            ST_LATCH: state_nx = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt == GW'(GAP - 1)) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // LATCH is the edge where the chain takes the LSB, so frame_valid rises with it.
    always_comb begin
        gnt_d = '0;
        sr_d  = 1'b0;
        fv_d  = 1'b0;
        case (state)
            ST_IDLE:  gnt_d = arb_gnt;
            ST_SHIFT: sr_d  = word[bit_cnt];
            ST_LATCH: fv_d  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q      <= '0;
            sr_q       <= 1'b0;
            fv_q       <= 1'b0;
            frame_id_q <= '0;
            ptr        <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            word       <= '0;
        end else begin
            gnt_q <= gnt_d;
            sr_q  <= sr_d;
            fv_q  <= fv_d;
            case (state)
                ST_IDLE: if (arb_any) begin
                    word       <= sif.data[arb_idx*WIDTH +: WIDTH];
                    frame_id_q <= arb_idx;
                    ptr        <= (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                    bit_cnt    <= CW'(WIDTH - 1);
                end
                ST_SHIFT: bit_cnt <= bit_cnt - CW'(1);
                ST_LATCH: gap_cnt <= '0;
                ST_GAP:   gap_cnt <= gap_cnt + GW'(1);
                default:  ;
            endcase
        end
    end

`ifdef SHIFT_SCHED_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 frame_cnt_q <= '0;
        else if (state == ST_LATCH) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end

    assign sif.frame_cnt = frame_cnt_q;
`else
    assign sif.frame_cnt = '0;
`endif

    assign sif.gnt         = gnt_q;
    assign sif.sr_data     = sr_q;
    assign sif.frame_valid = fv_q;
    assign sif.frame_id    = frame_id_q;
    assign sif.busy        = (state != ST_IDLE);
    assign sif.dbg_state   = state;

endmodule

// File: tb/tb_shift_frame_scheduler.sv
// Directed bench for shift_frame_scheduler with a model 8-stage chain on sr_data.
module tb_shift_frame_scheduler;
    import shift_sched_pkg::*;

    localparam int N_REQ = 3;
    localparam int WIDTH = 8;
    localparam int GAP   = 1;
    localparam int PERIOD_CYC = WIDTH + 2 + GAP;
`ifdef SHIFT_SCHED_FRAME_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shift_frame_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) sif ();

    shift_frame_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    // Existing shift chain: first bit in ends at the last stage (MSB side).
    logic [WIDTH-1:0] chain;
    always @(posedge clk) chain <= {chain[WIDTH-2:0], sif.sr_data};

    logic [WIDTH-1:0] exp_q[$];
    int exp_id_q[$];
    int grant_log[$];
    int fv_cyc[$];
    int cyc      = 0;
    int fv_count = 0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (sif.gnt != '0) begin
                check("gnt_onehot", $countones(sif.gnt), 1);
                check("gnt_fv_excl", sif.frame_valid, 0);
                for (int i = 0; i < N_REQ; i++) if (sif.gnt[i]) grant_log.push_back(i);
            end
            if (sif.frame_valid) begin
                fv_count++;
                fv_cyc.push_back(cyc);
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("frame_taps", chain, exp_q.pop_front());
                    check("frame_id", sif.frame_id, exp_id_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        sif.req  = '0;
        sif.data = '0;
        step(2);
        reset = 1'b1;
        step(1);
        exp_q.delete();
        exp_id_q.delete();
        grant_log.delete();
        fv_cyc.delete();
        fv_count = 0;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        sif.data[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic expect_frame(input logic [WIDTH-1:0] w, input int id);
        exp_q.push_back(w);
        exp_id_q.push_back(id);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (fv_count < n && k < budget) begin
            step();
            k++;
        end
        check(tag, fv_count >= n, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] w1;
        int hold;
        int k;
        int order2[4];
        int order3[4];
        order2 = '{0, 1, 2, 0};
        order3 = '{0, 2, 0, 2};

        // Single frame, cycle-exact
        do_reset();
        check("rst_gnt", sif.gnt, 0);
        check("rst_sr_data", sif.sr_data, 0);
        check("rst_fv", sif.frame_valid, 0);
        check("rst_frame_id", sif.frame_id, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_frame_cnt", sif.frame_cnt, 0);
        check("rst_state", 32'(sif.dbg_state), 32'(ST_IDLE));
        w1 = 8'hA5;
        set_word(0, w1);
        expect_frame(w1, 0);
        sif.req = 3'b001;
        step();
        check("t1_gnt", sif.gnt, 3'b001);
        check("t1_busy", sif.busy, 1);
        sif.req = '0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            step();
            check("t1_sr_bit", sif.sr_data, w1[b]);
            check("t1_no_fv", sif.frame_valid, 0);
            check("t1_gnt_clear", sif.gnt, 0);
        end
        step();
        check("t1_fv", sif.frame_valid, 1);
        check("t1_taps", chain, w1);
        check("t1_sr_zero", sif.sr_data, 0);
        check("t1_busy_gap", sif.busy, 1);
        check("t1_frame_cnt", sif.frame_cnt, CNT_EN);
        step();
        check("t1_fv_pulse", sif.frame_valid, 0);
        check("t1_idle", sif.busy, 0);

        // Contention with pointer wrap
        do_reset();
        set_word(0, 8'h11);
        set_word(1, 8'h22);
        set_word(2, 8'h33);
        expect_frame(8'h11, 0);
        expect_frame(8'h22, 1);
        expect_frame(8'h33, 2);
        expect_frame(8'h11, 0);
        sif.req = 3'b111;
        wait_frames("t2_timeout", 4, 60);
        sif.req = '0;
        step(15);
        check("t2_grant_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_grant_order", grant_log[i], order2[i]);
        check("t2_fv_cnt", fv_count, 4);
        for (int i = 0; i < 3; i++) check("t2_period", fv_cyc[i+1] - fv_cyc[i], PERIOD_CYC);
        check("t2_drained", exp_q.size(), 0);
        check("t2_frame_cnt", sif.frame_cnt, 4 * CNT_EN);

        // Fairness: req[2] held, req[0] re-raised after each grant
        do_reset();
        set_word(0, 8'h5A);
        set_word(2, 8'hC3);
        expect_frame(8'h5A, 0);
        expect_frame(8'hC3, 2);
        expect_frame(8'h5A, 0);
        expect_frame(8'hC3, 2);
        sif.req = 3'b101;
        hold = 0;
        k = 0;
        while (fv_count < 4 && k < 80) begin
            step();
            k++;
            if (sif.gnt[0]) begin
                sif.req[0] = 1'b0;
                hold = 3;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) sif.req[0] = 1'b1;
            end
        end
        check("t3_timeout", fv_count >= 4, 1);
        sif.req = '0;
        step(15);
        check("t3_grant_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t3_grant_order", grant_log[i], order3[i]);
        check("t3_frame_cnt", sif.frame_cnt, 4 * CNT_EN);

        // Reset mid-shift abandons the frame and clears the pointer
        do_reset();
        set_word(0, 8'h81);
        set_word(1, 8'h7E);
        sif.req = 3'b001;
        step();
        check("t4_gnt", sif.gnt, 3'b001);
        sif.req = '0;
        step(4);
        reset = 1'b0;
        #1;
        check("t4_rst_sr_data", sif.sr_data, 0);
        check("t4_rst_busy", sif.busy, 0);
        check("t4_rst_fv", sif.frame_valid, 0);
        check("t4_rst_state", 32'(sif.dbg_state), 32'(ST_IDLE));
        check("t4_rst_frame_cnt", sif.frame_cnt, 0);
        step(2);
        reset = 1'b1;
        step(12);
        check("t4_no_fv", fv_count, 0);
        grant_log.delete();
        expect_frame(8'h81, 0);
        sif.req = 3'b011;
        step();
        check("t4_regrant_ptr0", sif.gnt, 3'b001);
        sif.req = '0;
        wait_frames("t4_timeout", 1, 20);
        step(5);
        check("t4_fv_cnt", fv_count, 1);

        // Withdrawn request is never granted
        do_reset();
        set_word(0, 8'h3C);
        set_word(1, 8'hF0);
        expect_frame(8'h3C, 0);
        sif.req = 3'b001;
        step();
        sif.req = '0;
        step(2);
        sif.req = 3'b010;
        step();
        sif.req = '0;
        wait_frames("t5_timeout", 1, 20);
        step(15);
        check("t5_grant_cnt", grant_log.size(), 1);
        check("t5_grant_id", grant_log[0], 0);
        check("t5_fv_cnt", fv_count, 1);
        check("t5_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
